// File: rtl/input_device.sv
`default_nettype none
// input_device: operator entry of a signed 28-bit value from hex switches and
// debounced buttons, delivered to the processor on an input-instruction handshake.
module input_device #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [3:0]  sw,
  input  logic        btn_digit,
  input  logic        btn_sign,
  input  logic        btn_clear,
  input  logic        btn_commit,
  input  logic        in_req,
  output logic [27:0] in_data,
  output logic        in_valid,
  output logic [27:0] entry_val,
  output logic        armed
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic {
    S_EDIT  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  logic [3:0] btn_raw;
  logic [3:0] sw_s1_q, sw_s2_q;
  logic [3:0] btn_s1_q, btn_s2_q;
  logic [3:0] pulse;

  assign btn_raw = {btn_commit, btn_clear, btn_sign, btn_digit};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          lvl_prev_q;
    logic          pulse_q;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q      <= '0;
        lvl_q      <= 1'b0;
        lvl_prev_q <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        lvl_prev_q <= lvl_q;
        pulse_q    <= lvl_q & ~lvl_prev_q;
        if (btn_s2_q[i] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_q <= '0;
          lvl_q <= btn_s2_q[i];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign pulse[i] = pulse_q;
  end

  logic p_digit, p_sign, p_clear, p_commit;
  assign p_digit  = pulse[0];
  assign p_sign   = pulse[1];
  assign p_clear  = pulse[2];
  assign p_commit = pulse[3];

  state_t      state_q, state_d;
  logic [26:0] mag_q, mag_d;
  logic        sign_q, sign_d;
  logic [27:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        armed_q, armed_d;
  logic [27:0] ev_q;
  logic [27:0] twos;

  // Negative zero wraps to zero through the +1 carry-out truncation.
  assign twos = sign_q ? (~{1'b0, mag_q} + 28'd1) : {1'b0, mag_q};

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    data_d  = data_q;
    valid_d = 1'b0;
    armed_d = armed_q;
    case (state_q)
      S_EDIT: begin
        if (p_clear) begin
          mag_d  = '0;
          sign_d = 1'b0;
        end else if (p_commit) begin
          data_d  = twos;
          armed_d = 1'b1;
          state_d = S_ARMED;
        end else if (p_sign) begin
          sign_d = ~sign_q;
        end else if (p_digit) begin
          mag_d = {mag_q[22:0], sw_s2_q};
        end
      end
      S_ARMED: begin
        if (in_req) begin
          valid_d = 1'b1;
          armed_d = 1'b0;
          mag_d   = '0;
          sign_d  = 1'b0;
          state_d = S_EDIT;
        end else if (p_clear) begin
          armed_d = 1'b0;
          state_d = S_EDIT;
        end
      end
      default: state_d = S_EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_EDIT;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
      ev_q    <= twos;
    end
  end

  assign in_data   = data_q;
  assign in_valid  = valid_q;
  assign entry_val = ev_q;
  assign armed     = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_input_device.sv
`default_nettype none
// tb_input_device: directed scenarios plus random button/request traffic,
// checked every cycle against a behavioural model of the entry device.
module tb_input_device;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [3:0]  sw = '0;
  logic [3:0]  braw = '0;
  logic        in_req = 1'b0;
  logic [27:0] in_data;
  logic        in_valid;
  logic [27:0] entry_val;
  logic        armed;

  int n_pass = 0;
  int n_total = 0;

  input_device #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sw         (sw),
    .btn_digit  (braw[0]),
    .btn_sign   (braw[1]),
    .btn_clear  (braw[2]),
    .btn_commit (braw[3]),
    .in_req     (in_req),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .entry_val  (entry_val),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [26:0] m_mag;
  bit          m_sign;
  logic [27:0] m_ev, m_data;
  bit          m_valid, m_armed;
  bit   [3:0]  m_h1, m_h2, m_lvl, m_rose, m_pulse;
  logic [3:0]  s_h1, s_h2;
  int          m_run [4];

  function automatic logic [27:0] conv(input logic [26:0] mg, input bit sg);
    logic [27:0] v;
    v = {1'b0, mg};
    return sg ? (28'd0 - v) : v;
  endfunction

  task automatic model_reset();
    m_mag = '0; m_sign = 0; m_ev = '0; m_data = '0; m_valid = 0; m_armed = 0;
    m_h1 = '0; m_h2 = '0; m_lvl = '0; m_rose = '0; m_pulse = '0;
    s_h1 = '0; s_h2 = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    bit [3:0]    p;
    logic [27:0] cur;
    if (!n_rst) begin
      model_reset();
      return;
    end
    p   = m_pulse;
    cur = conv(m_mag, m_sign);
    m_valid = 0;
    if (!m_armed) begin
      if (p[2]) begin
        m_mag = '0; m_sign = 0;
      end else if (p[3]) begin
        m_data = cur; m_armed = 1;
      end else if (p[1]) begin
        m_sign = !m_sign;
      end else if (p[0]) begin
        m_mag = 27'(({5'd0, m_mag} * 32'd16) + {28'd0, s_h2});
      end
    end else if (in_req) begin
      m_valid = 1; m_armed = 0; m_mag = '0; m_sign = 0;
    end else if (p[2]) begin
      m_armed = 0;
    end
    m_ev = cur;
    m_pulse = m_rose;
    for (int i = 0; i < 4; i++) begin
      m_rose[i] = 0;
      if (m_h2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i]  = !m_lvl[i];
          m_run[i]  = 0;
          m_rose[i] = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_h2 = m_h1; m_h1 = braw;
    s_h2 = s_h1; s_h1 = sw;
  endtask

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    check("entry_val", entry_val, m_ev);
    check("in_data", in_data, m_data);
    check("in_valid", {27'd0, in_valid}, {27'd0, m_valid});
    check("armed", {27'd0, armed}, {27'd0, m_armed});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic press(input int b);
    braw[b] = 1'b1;
    repeat (DEB + 6) tick();
    braw[b] = 1'b0;
    repeat (DEB + 6) tick();
  endtask

  task automatic key(input logic [3:0] d);
    sw = d;
    repeat (3) tick();
    press(0);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    check("rst_entry_val", entry_val, 28'h0);
    check("rst_in_data", in_data, 28'h0);
    check("rst_in_valid", {27'd0, in_valid}, 28'h0);
    check("rst_armed", {27'd0, armed}, 28'h0);

    // Digit latency: pulse after 7th edge, mag on 8th, entry_val on 9th.
    sw = 4'hA;
    repeat (3) tick();
    braw[0] = 1'b1;
    repeat (8) tick();
    check("lat_before", entry_val, 28'h0);
    tick();
    check("lat_after", entry_val, 28'h000000A);
    tick();
    braw[0] = 1'b0;
    repeat (DEB + 6) tick();

    // Short glitch is absorbed.
    braw[0] = 1'b1;
    repeat (3) tick();
    braw[0] = 1'b0;
    repeat (DEB + 6) tick();
    check("glitch", entry_val, 28'h000000A);

    press(2);
    key(4'h1); key(4'h2); key(4'h3);
    press(1);
    check("neg_123", entry_val, 28'hFFFFEDD);
    press(3);
    check("commit_armed", {27'd0, armed}, 28'h1);
    in_req = 1'b1;
    tick();
    check("hs_valid", {27'd0, in_valid}, 28'h1);
    check("hs_data", in_data, 28'hFFFFEDD);
    in_req = 1'b0;
    tick();
    check("hs_valid_drop", {27'd0, in_valid}, 28'h0);
    check("hs_armed", {27'd0, armed}, 28'h0);
    check("hs_entry", entry_val, 28'h0);

    for (int i = 0; i < 8; i++) key(4'hF);
    check("wrap_pos", entry_val, 28'h7FFFFFF);
    press(1);
    check("wrap_neg", entry_val, 28'h8000001);

    press(2);
    key(4'h5);
    press(3);
    key(4'h7);
    press(1);
    check("frozen_entry", entry_val, 28'h0000005);
    check("frozen_data", in_data, 28'h0000005);
    check("frozen_armed", {27'd0, armed}, 28'h1);
    press(2);
    check("cancel_armed", {27'd0, armed}, 28'h0);
    check("cancel_entry", entry_val, 28'h0000005);
    press(2);
    press(1);
    check("neg_zero", entry_val, 28'h0);

    // Clear and commit in the same cycle: clear wins.
    key(4'h3);
    braw[2] = 1'b1; braw[3] = 1'b1;
    repeat (DEB + 6) tick();
    braw = '0;
    repeat (DEB + 6) tick();
    check("clr_commit_armed", {27'd0, armed}, 28'h0);
    check("clr_commit_entry", entry_val, 28'h0);

    // in_req and clear pulse in the same ARMED cycle: handshake wins.
    key(4'h9);
    press(3);
    braw[2] = 1'b1;
    repeat (7) tick();
    in_req = 1'b1;
    tick();
    check("req_clr_valid", {27'd0, in_valid}, 28'h1);
    check("req_clr_data", in_data, 28'h0000009);
    in_req = 1'b0;
    repeat (3) tick();
    braw[2] = 1'b0;
    repeat (DEB + 6) tick();

    // Asynchronous reset mid-entry.
    key(4'h1); key(4'h2); key(4'h3);
    check("pre_reset_entry", entry_val, 28'h0000123);
    press(3);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_entry", entry_val, 28'h0);
    check("async_data", in_data, 28'h0);
    check("async_valid", {27'd0, in_valid}, 28'h0);
    check("async_armed", {27'd0, armed}, 28'h0);
    model_reset();
    repeat (2) tick();
    n_rst = 1'b1;
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) braw[b] = ~braw[b];
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) in_req = ~in_req;
      tick();
    end
    braw = '0;
    in_req = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
